// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the one-outstanding-request instruction bus
// handshake and registers the fetched word into the fields consumed by decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] f_nextpc_i,
    input  logic        f_indelayslot_i,
    input  logic        d_stall_i,
    input  logic        flush_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] f_nowpc_o,
    output logic [31:0] f_pcplus4_o,
    output logic [31:0] ftod_pc_o,
    output logic [31:0] ftod_pcplus4_o,
    output logic [31:0] ftod_instr_o,
    output logic        ftod_addr_err_if_o,
    output logic        ftod_in_delay_slot_o,
    output logic        ftod_is_instr_o
);

    // state   | meaning
    // REQ     | request pc (or report a misaligned pc as error data)
    // WAIT    | request accepted, waiting for data_ok
    // HOLD    | word captured while decode stalls
    // DISCARD | flushed request outstanding, drop its response
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ftod_pc_q, ftod_pc_d;
    logic [31:0] ftod_pcplus4_q, ftod_pcplus4_d;
    logic [31:0] ftod_instr_q, ftod_instr_d;
    logic        ftod_err_q, ftod_err_d;
    logic        ftod_ds_q, ftod_ds_d;
    logic        ftod_is_q, ftod_is_d;

    logic        misaligned;
    logic        have_data;
    logic [31:0] fetch_data;
    logic        handoff;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= S_REQ;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            case (state_q)
                S_REQ:             state_d = (inst_req_o && inst_addr_ok_i) ? S_DISCARD : S_REQ;
                S_WAIT, S_DISCARD: state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                default:           state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ:     if (inst_req_o && inst_addr_ok_i) state_d = S_WAIT;
                S_WAIT:    if (inst_data_ok_i) state_d = d_stall_i ? S_HOLD : S_REQ;
                S_HOLD:    if (!d_stall_i) state_d = S_REQ;
                S_DISCARD: if (inst_data_ok_i) state_d = S_REQ;
                default:   state_d = S_REQ;
            endcase
        end
    end

    // A misaligned pc never reaches the bus; it is delivered as a zero word flagged as an error.
    always_comb begin
        misaligned = (pc_q[1:0] != 2'b00);
        inst_req_o = resetn_i && (state_q == S_REQ) && !misaligned;
        have_data  = 1'b0;
        fetch_data = 32'h0;
        case (state_q)
            S_REQ:   have_data = misaligned;
            S_WAIT: begin
                have_data  = inst_data_ok_i;
                fetch_data = inst_rdata_i;
            end
            S_HOLD: begin
                have_data  = 1'b1;
                fetch_data = buf_q;
            end
            default: have_data = 1'b0;
        endcase
        handoff = have_data && !d_stall_i && !flush_i;
    end

    always_comb begin
        pc_d           = pc_q;
        buf_d          = buf_q;
        ftod_pc_d      = ftod_pc_q;
        ftod_pcplus4_d = ftod_pcplus4_q;
        ftod_instr_d   = ftod_instr_q;
        ftod_err_d     = ftod_err_q;
        ftod_ds_d      = ftod_ds_q;
        ftod_is_d      = ftod_is_q;
        if (flush_i || handoff) pc_d = f_nextpc_i;
        if (flush_i) begin
            buf_d        = 32'h0;
            ftod_is_d    = 1'b0;
            ftod_instr_d = 32'h0;
            ftod_err_d   = 1'b0;
        end else if (handoff) begin
            ftod_pc_d      = pc_q;
            ftod_pcplus4_d = pc_q + 32'd4;
            ftod_instr_d   = fetch_data;
            ftod_err_d     = misaligned;
            ftod_ds_d      = f_indelayslot_i;
            ftod_is_d      = 1'b1;
        end else if (!d_stall_i) begin
            ftod_is_d    = 1'b0;
            ftod_instr_d = 32'h0;
            ftod_err_d   = 1'b0;
        end else if (state_q == S_WAIT && inst_data_ok_i) begin
            buf_d = inst_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pc_q           <= RESET_PC;
            buf_q          <= 32'h0;
            ftod_pc_q      <= 32'h0;
            ftod_pcplus4_q <= 32'h0;
            ftod_instr_q   <= 32'h0;
            ftod_err_q     <= 1'b0;
            ftod_ds_q      <= 1'b0;
            ftod_is_q      <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            buf_q          <= buf_d;
            ftod_pc_q      <= ftod_pc_d;
            ftod_pcplus4_q <= ftod_pcplus4_d;
            ftod_instr_q   <= ftod_instr_d;
            ftod_err_q     <= ftod_err_d;
            ftod_ds_q      <= ftod_ds_d;
            ftod_is_q      <= ftod_is_d;
        end
    end

    assign inst_addr_o          = pc_q;
    assign f_nowpc_o            = pc_q;
    assign f_pcplus4_o          = pc_q + 32'd4;
    assign ftod_pc_o            = ftod_pc_q;
    assign ftod_pcplus4_o       = ftod_pcplus4_q;
    assign ftod_instr_o         = ftod_instr_q;
    assign ftod_addr_err_if_o   = ftod_err_q;
    assign ftod_in_delay_slot_o = ftod_ds_q;
    assign ftod_is_instr_o      = ftod_is_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: bus responder, transaction-level fetch model compared every cycle,
// and directed scenarios with hand-computed expectations.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] f_nextpc;
    logic        ids = 1'b0;
    logic        d_stall = 1'b0;
    logic        flush = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] f_nowpc, f_pcplus4, ftod_pc, ftod_pcplus4, ftod_instr;
    logic        ftod_addr_err_if, ftod_in_delay_slot, ftod_is_instr;

    logic        ack_en = 1'b1;
    logic        ovr = 1'b0;
    logic [31:0] nxt_val = 32'h0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        saw_beef = 1'b0;

    always #5 clk = ~clk;

    assign f_nextpc     = ovr ? nxt_val : f_nowpc + 32'd4;
    assign inst_addr_ok = inst_req & ack_en;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk), .resetn_i(resetn), .f_nextpc_i(f_nextpc), .f_indelayslot_i(ids),
        .d_stall_i(d_stall), .flush_i(flush), .inst_req_o(inst_req), .inst_addr_o(inst_addr),
        .inst_addr_ok_i(inst_addr_ok), .inst_data_ok_i(data_ok), .inst_rdata_i(rdata),
        .f_nowpc_o(f_nowpc), .f_pcplus4_o(f_pcplus4), .ftod_pc_o(ftod_pc),
        .ftod_pcplus4_o(ftod_pcplus4), .ftod_instr_o(ftod_instr),
        .ftod_addr_err_if_o(ftod_addr_err_if), .ftod_in_delay_slot_o(ftod_in_delay_slot),
        .ftod_is_instr_o(ftod_is_instr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: explicit entries, otherwise a pattern derived from the address.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h13570000;
    endfunction

    int          lat = 1;
    int          cnt = 0;
    logic        acc_n = 1'b0;
    logic [31:0] acc_addr_n = 32'h0;
    logic [31:0] pend_addr = 32'h0;

    always @(negedge clk) begin
        acc_n      = inst_req & inst_addr_ok;
        acc_addr_n = inst_addr;
    end

    always @(posedge clk) begin
        #1;
        data_ok = 1'b0;
        if (!resetn) begin
            cnt = 0;
        end else begin
            if (acc_n) begin
                cnt       = lat;
                pend_addr = acc_addr_n;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    data_ok = 1'b1;
                    rdata   = mem_rd(pend_addr);
                end
            end
        end
    end

    // Model: pc, whether a bus request is outstanding (and doomed), and a held word.
    logic [31:0] m_pc, m_hd, m_fpc, m_fp4, m_instr, m_npc, m_dat;
    logic        m_out, m_drop, m_hv, m_err, m_ds, m_is;
    logic        m_req, m_acc, m_resp, m_mis, m_have;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pc = RST_PC; m_out = 0; m_drop = 0; m_hv = 0; m_hd = 0;
            m_fpc = 0; m_fp4 = 0; m_instr = 0; m_err = 0; m_ds = 0; m_is = 0;
        end else begin
            m_npc  = ovr ? nxt_val : m_pc + 32'd4;
            m_mis  = (m_pc % 4) != 0;
            m_req  = !m_mis && !m_out && !m_hv;
            m_acc  = m_req && ack_en;
            m_resp = m_out && data_ok;
            m_have = 0;
            m_dat  = 0;
            if (m_hv) begin
                m_have = 1; m_dat = m_hd;
            end else if (m_resp && !m_drop) begin
                m_have = 1; m_dat = rdata;
            end else if (!m_out && m_mis) begin
                m_have = 1;
            end
            if (flush) begin
                m_pc = m_npc; m_hv = 0;
                m_is = 0; m_instr = 0; m_err = 0;
                m_drop = m_acc || (m_out && !data_ok);
                m_out  = m_drop;
            end else begin
                if (m_have && !d_stall) begin
                    m_fpc = m_pc; m_fp4 = m_pc + 32'd4; m_instr = m_dat; m_err = m_mis;
                    m_ds = ids; m_is = 1; m_pc = m_npc; m_hv = 0;
                end else if (!d_stall) begin
                    m_is = 0; m_instr = 0; m_err = 0;
                end else if (m_resp && !m_drop) begin
                    m_hv = 1; m_hd = m_dat;
                end
                if (m_resp) begin
                    m_out = 0; m_drop = 0;
                end
                if (m_acc) begin
                    m_out = 1; m_drop = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("inst_req", inst_req, resetn && (m_pc % 4 == 0) && !m_out && !m_hv);
        check("inst_addr", inst_addr, m_pc);
        check("f_nowpc", f_nowpc, m_pc);
        check("f_pcplus4", f_pcplus4, m_pc + 32'd4);
        check("ftod_pc", ftod_pc, m_fpc);
        check("ftod_pcplus4", ftod_pcplus4, m_fp4);
        check("ftod_instr", ftod_instr, m_instr);
        check("ftod_addr_err_if", ftod_addr_err_if, m_err);
        check("ftod_in_delay_slot", ftod_in_delay_slot, m_ds);
        check("ftod_is_instr", ftod_is_instr, m_is);
        if (ftod_is_instr && ftod_instr == 32'hDEADBEEF) saw_beef = 1'b1;
    end

    task automatic wait_handoff();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ftod_is_instr && k < 50);
        check("handoff_seen", ftod_is_instr, 1);
    endtask

    task automatic wait_accept();
        int k = 0;
        while (!(inst_req && inst_addr_ok) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_seen", inst_req & inst_addr_ok, 1);
    endtask

    task automatic wait_req();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!inst_req && k < 50);
        check("req_seen", inst_req, 1);
    endtask

    initial begin
        mem[RST_PC] = 32'h24080001;
        repeat (3) @(negedge clk);
        check("rst_is_instr", ftod_is_instr, 0);
        check("rst_nowpc", f_nowpc, RST_PC);
        check("rst_req", inst_req, 0);
        @(posedge clk);
        #2 resetn = 1'b1;

        // first fetch
        @(negedge clk);
        check("first_req", inst_req, 1);
        check("first_addr", inst_addr, RST_PC);
        wait_handoff();
        check("t1_ftod_pc", ftod_pc, 32'hBFC00000);
        check("t1_ftod_instr", ftod_instr, 32'h24080001);
        check("t1_nowpc", f_nowpc, 32'hBFC00004);

        // decode stall while data returns
        wait_accept();
        d_stall = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_no_req", inst_req, 0);
        check("stall_ftod_pc", ftod_pc, 32'hBFC00000);
        check("stall_nowpc", f_nowpc, 32'hBFC00004);
        d_stall = 1'b0;
        wait_handoff();
        check("unstall_ftod_pc", ftod_pc, 32'hBFC00004);
        check("unstall_instr", ftod_instr, 32'hBFC00004 ^ 32'h13570000);
        check("unstall_req", inst_req, 1);
        check("unstall_addr", inst_addr, 32'hBFC00008);

        // misaligned next pc
        ovr = 1'b1;
        nxt_val = 32'h80000002;
        wait_handoff();
        nxt_val = 32'hBFC00010;
        check("mis_no_req", inst_req, 0);
        wait_handoff();
        check("mis_err", ftod_addr_err_if, 1);
        check("mis_instr", ftod_instr, 0);
        check("mis_pc", ftod_pc, 32'h80000002);
        ovr = 1'b0;

        // flush while waiting, then again while discarding
        lat = 3;
        wait_accept();
        mem[inst_addr] = 32'hDEADBEEF;
        @(negedge clk);
        flush = 1'b1;
        ovr = 1'b1;
        nxt_val = 32'hBFC00200;
        @(negedge clk);
        nxt_val = 32'hBFC00380;
        @(negedge clk);
        flush = 1'b0;
        ovr = 1'b0;
        lat = 1;
        wait_req();
        check("flush_addr", inst_addr, 32'hBFC00380);

        // delay slot marking
        wait_handoff();
        ids = 1'b1;
        wait_handoff();
        check("ds_set", ftod_in_delay_slot, 1);
        ids = 1'b0;
        wait_handoff();
        check("ds_clear", ftod_in_delay_slot, 0);

        // async reset mid-WAIT
        lat = 3;
        wait_accept();
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("ar_is_instr", ftod_is_instr, 0);
        check("ar_pc", ftod_pc, 0);
        check("ar_instr", ftod_instr, 0);
        check("ar_nowpc", f_nowpc, RST_PC);
        check("ar_req", inst_req, 0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        lat = 1;
        wait_req();
        check("ar_first_addr", inst_addr, RST_PC);
        repeat (5) @(negedge clk);
        check("no_stale_word", saw_beef, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage, directly upstream of the decode stage.
- Owns the architectural PC and drives the SRAM-like instruction bus: one outstanding request, req/addr_ok/data_ok handshake.
- Registers the fetched instruction into the F->D pipeline fields consumed by decode: pc, pcplus4, instr, addr_err_if, in_delay_slot, is_instr.
- Advances the PC to the f_nextpc value that decode computes.

Parameters:
RESET_PC, 32'hBFC00000, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
f_nextpc  in  32  next PC from decode (branch/jump/eret/exception already muxed)
f_indelayslot  in  1  decode holds a branch/jump; next handed-off instr is a delay slot
d_stall  in  1  decode cannot accept a new instruction this cycle
flush  in  1  exception/eret redirect; discard in-flight and held instr, PC <= f_nextpc
inst_req  out  1  instruction request valid
inst_addr  out  32  request address (= pc)
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
f_nowpc  out  32  current PC register
f_pcplus4  out  32  pc + 4
ftod_pc  out  32  PC of instruction presented to decode
ftod_pcplus4  out  32  ftod_pc + 4
ftod_instr  out  32  instruction word to decode
ftod_addr_err_if  out  1  fetch address misaligned
ftod_in_delay_slot  out  1  instruction is a branch delay slot
ftod_is_instr  out  1  ftod fields hold a real instruction (0 = bubble)

Behaviour:
- Reset (resetn=0, async):
  - pc=RESET_PC; state=REQ; inst_req=0 during reset.
  - All ftod_* outputs = 0.
  - Holding buffer empty.
- States:
  - REQ: inst_req=1 if pc[1:0]==0.
    - addr_ok -> WAIT.
    - If pc[1:0]!=0: no request; the cycle counts as having data, with instr=0 and addr_err_if=1.
  - WAIT: inst_req=0; on data_ok capture rdata.
    - d_stall=0 -> hand off, REQ.
    - d_stall=1 -> HOLD.
  - HOLD: instruction held in internal buffer; hand off when d_stall=0 -> REQ.
  - DISCARD: a flushed request is outstanding; the next data_ok is dropped -> REQ.
- Handoff (have_data & ~d_stall & ~flush), on the next edge:
  - ftod_pc=pc, ftod_pcplus4=pc+4, ftod_instr=data, ftod_addr_err_if=(pc[1:0]!=0).
  - ftod_in_delay_slot=f_indelayslot, ftod_is_instr=1.
  - pc <= f_nextpc.
- Handoff of data arriving on data_ok may occur in the same cycle (WAIT -> REQ, no HOLD). Fetch-to-decode latency is 1 edge after data_ok.
- No handoff while ~d_stall:
  - ftod_is_instr=0, ftod_instr=0.
  - ftod_pc/pcplus4/in_delay_slot keep their last values.
- d_stall=1: all ftod_* outputs hold; pc holds.
- flush=1 (highest priority, any state):
  - pc <= f_nextpc; HOLD buffer cleared.
  - ftod_is_instr=0, ftod_instr=0, ftod_addr_err_if=0.
  - Next state: WAIT, or REQ with addr_ok this cycle -> DISCARD.
  - WAIT with data_ok this cycle -> REQ (data dropped).
  - DISCARD stays DISCARD until its data_ok.
  - Otherwise -> REQ.
- flush during DISCARD: the pc update applies; still drop exactly one response.
- inst_addr is stable while inst_req=1 and addr_ok=0. pc never changes with a request pending acceptance except on flush.
- f_nowpc, f_pcplus4 are combinational from pc; pc+4 wraps modulo 2^32.
- At most one outstanding request. data_ok in REQ (no request outstanding) is ignored.

Test Plan:
- Reset release, addr_ok and data_ok both 1 cycle later, rdata=32'h24080001, d_stall=0 -> inst_addr=BFC00000 first; next edge ftod_pc=BFC00000, ftod_instr=24080001, ftod_is_instr=1; pc=f_nextpc=BFC00004.
- d_stall=1 for 3 cycles when data_ok arrives -> state HOLD, ftod outputs hold, no new inst_req; d_stall falls -> instruction delivered, one cycle later inst_req for the next pc.
- f_nextpc=32'h80000002 -> no inst_req; ftod_addr_err_if=1, ftod_instr=0, ftod_pc=80000002.
- Flush in WAIT with f_nextpc=BFC00380 -> DISCARD; stale data_ok (rdata=DEADBEEF) never appears on ftod_instr; next request addr=BFC00380.
- Branch delivered with f_indelayslot=1 on the following handoff -> delay-slot instruction has ftod_in_delay_slot=1; the instruction after it has 0.
- Assert resetn=0 mid-WAIT -> all ftod_* outputs 0 immediately, pc=BFC00000; after release the first request is at BFC00000.
